// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: sequencer state codes, error
// display pattern, legal-opcode bound and the ALU opcode values.
package calc_pkg;

  localparam int CALC_DATA_W = 32;
  localparam int CALC_OP_W   = 5;
  localparam int CALC_SH_W   = 5;

  localparam int                     OP_NUM      = 13;
  localparam logic [CALC_DATA_W-1:0] ERR_PATTERN = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    S_GET_A = 2'd0,
    S_GET_B = 2'd1,
    S_EXEC  = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  localparam logic [CALC_OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [CALC_OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [CALC_OP_W-1:0] OP_SRA  = 5'd4;
  localparam logic [CALC_OP_W-1:0] OP_SRAV = 5'd7;
  localparam logic [CALC_OP_W-1:0] OP_SLT  = 5'd12;

endpackage

// File: rtl/calc_op_sequencer_key_edge.sv
// key_edge: history register plus rising-edge pulse for a debounced key.
// The first cycle after reset only primes the history, so a key held through reset yields no pulse.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic key_q;
  logic armed;

  // History of the key level and the post-reset arming flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      key_q <= key;
      armed <= 1'b1;
    end
  end

  assign pulse = key & ~key_q & armed;

endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: gathers operands/opcode from switches, drives the ALU and holds the result.
// Define CALC_CHAIN_EN to chain a successful result into operand A of the next operation.
module calc_op_sequencer #(
  parameter int                 DATA_W      = calc_pkg::CALC_DATA_W,
  parameter int                 OP_W        = calc_pkg::CALC_OP_W,
  parameter int                 SH_W        = calc_pkg::CALC_SH_W,
  parameter int                 OP_NUM      = calc_pkg::OP_NUM,
  parameter logic [DATA_W-1:0]  ERR_PATTERN = calc_pkg::ERR_PATTERN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [OP_W-1:0]   sw_op,
  input  logic [SH_W-1:0]   sw_shamt,
  input  logic              key_enter,
  input  logic              key_clear,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SH_W-1:0]   alu_c,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_error,
  output logic [DATA_W-1:0] disp_value,
  output logic              err_flag,
  output logic [1:0]        state_led,
  output logic              done
);

  import calc_pkg::*;

  localparam logic [OP_W-1:0] OP_LIMIT = OP_W'(OP_NUM);

  state_t            state;
  state_t            state_nxt;
  logic [OP_W-1:0]   op_nxt;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic [SH_W-1:0]   c_nxt;
  logic [DATA_W-1:0] disp_nxt;
  logic              err_nxt;
  logic              done_nxt;
  logic              enter_pe;
  logic              clear_pe;

  key_edge u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .key   (key_enter),
    .pulse (enter_pe)
  );

  key_edge u_clear_edge (
    .clk   (clk),
    .reset (reset),
    .key   (key_clear),
    .pulse (clear_pe)
  );

  // Next-state and next-output decode; clear overrides any enter in the same cycle.
  always_comb begin
    state_nxt = state;
    op_nxt    = alu_op;
    a_nxt     = alu_a;
    b_nxt     = alu_b;
    c_nxt     = alu_c;
    disp_nxt  = disp_value;
    err_nxt   = err_flag;
    done_nxt  = 1'b0;
    if (clear_pe) begin
      state_nxt = S_GET_A;
      op_nxt    = '0;
      a_nxt     = '0;
      b_nxt     = '0;
      c_nxt     = '0;
      disp_nxt  = '0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        S_GET_A: begin
          disp_nxt = sw_data;
          if (enter_pe) begin
            a_nxt     = sw_data;
            state_nxt = S_GET_B;
          end else begin
            state_nxt = S_GET_A;
          end
        end
        S_GET_B: begin
          disp_nxt = sw_data;
          if (enter_pe) begin
            b_nxt     = sw_data;
            op_nxt    = sw_op;
            c_nxt     = sw_shamt;
            state_nxt = S_EXEC;
          end else begin
            state_nxt = S_GET_B;
          end
        end
        // ALU inputs have been stable for a full cycle; capture its outcome.
        S_EXEC: begin
          if (alu_error || (alu_op >= OP_LIMIT)) begin
            err_nxt  = 1'b1;
            disp_nxt = ERR_PATTERN;
          end else begin
            err_nxt  = 1'b0;
            disp_nxt = alu_result;
          end
          done_nxt  = 1'b1;
          state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (enter_pe) begin
            err_nxt = 1'b0;
`ifdef CALC_CHAIN_EN
            if (!err_flag) begin
              a_nxt     = disp_value;
              state_nxt = S_GET_B;
            end else begin
              state_nxt = S_GET_A;
            end
`else
            state_nxt = S_GET_A;
`endif
          end else begin
            state_nxt = S_SHOW;
          end
        end
        default: begin
          state_nxt = S_GET_A;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_GET_A;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= '0;
      disp_value <= '0;
      err_flag   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      alu_op     <= op_nxt;
      alu_a      <= a_nxt;
      alu_b      <= b_nxt;
      alu_c      <= c_nxt;
      disp_value <= disp_nxt;
      err_flag   <= err_nxt;
      done       <= done_nxt;
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with a behavioural ALU stand-in.
// Honours CALC_CHAIN_EN the same way as the design.
module tb_calc_op_sequencer;

  import calc_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } alu_out_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] disp;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sw_data = 32'd0;
  logic [4:0]  sw_op = 5'd0;
  logic [4:0]  sw_shamt = 5'd0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_c;
  logic [31:0] alu_result;
  logic        alu_error;
  logic [31:0] disp_value;
  logic        err_flag;
  logic [1:0]  state_led;
  logic        done;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [31:0] cur_a = 32'd0;
  logic [31:0] last_disp = 32'd0;
  logic        last_err = 1'b0;
  logic        in_b = 1'b0;
  alu_out_t    alu_o;

  calc_op_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .sw_data    (sw_data),
    .sw_op      (sw_op),
    .sw_shamt   (sw_shamt),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .disp_value (disp_value),
    .err_flag   (err_flag),
    .state_led  (state_led),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: signed overflow detected by widening to 64 bits.
  function automatic alu_out_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op, input logic [4:0] sh);
    alu_out_t o;
    longint   s;
    o.err = 1'b0;
    o.res = a ^ b;
    s     = 64'sd0;
    if (op >= 5'd13) begin
      o.res = 32'h1234_5678;
      o.err = op[0];
    end else begin
      case (op)
        OP_ADD: begin
          s = longint'($signed(a)) + longint'($signed(b));
          o.res = s[31:0];
          o.err = (s != longint'($signed(s[31:0])));
        end
        OP_SUB: begin
          s = longint'($signed(a)) - longint'($signed(b));
          o.res = s[31:0];
          o.err = (s != longint'($signed(s[31:0])));
        end
        OP_SRA:  o.res = $signed(a) >>> sh;
        OP_SRAV: o.res = $signed(a) >>> b[4:0];
        OP_SLT:  o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: o.res = a ^ b;
      endcase
    end
    return o;
  endfunction

  always_comb alu_o = alu_model(alu_a, alu_b, alu_op, alu_c);
  assign alu_result = alu_o.res;
  assign alu_error  = alu_o.err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_disp", disp_value, e.disp);
        check("result_err", 32'(err_flag), 32'(e.err));
        check("result_alu_a", alu_a, e.a);
        check("result_alu_b", alu_b, e.b);
        check("result_alu_op", 32'(alu_op), 32'(e.op));
        check("result_alu_c", 32'(alu_c), 32'(e.sh));
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 32'(state_led), 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_alu_c"}, 32'(alu_c), 32'd0);
    check({tag, "_disp"}, disp_value, 32'd0);
    check({tag, "_err"}, 32'(err_flag), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic enter_a(input logic [31:0] a);
    sw_data = a;
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    check("a_state", 32'(state_led), 32'd1);
    check("a_load", alu_a, a);
    sw_data = ~a;
    @(negedge clk);
    check("b_disp_track", disp_value, ~a);
    cur_a = a;
    in_b = 1'b1;
  endtask

  task automatic run_b(input logic [31:0] b, input logic [4:0] op, input logic [4:0] sh);
    exp_t     e;
    alu_out_t o;
    o      = alu_model(cur_a, b, op, sh);
    e.a    = cur_a;
    e.b    = b;
    e.op   = op;
    e.sh   = sh;
    e.err  = o.err || (op >= 5'd13);
    e.disp = e.err ? 32'hEEEE_EEEE : o.res;
    exp_q.push_back(e);
    sw_data = b;
    sw_op = op;
    sw_shamt = sh;
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    check("exec_state", 32'(state_led), 32'd2);
    check("exec_alu_c", 32'(alu_c), 32'(sh));
    check("exec_done_low", 32'(done), 32'd0);
    sw_data = $urandom;
    @(negedge clk);
    check("show_state", 32'(state_led), 32'd3);
    @(negedge clk);
    check("done_one_pulse", 32'(done), 32'd0);
    check("show_hold", disp_value, e.disp);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    last_disp = e.disp;
    last_err = e.err;
    in_b = 1'b0;
  endtask

  task automatic leave_show();
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    check("leave_err_clear", 32'(err_flag), 32'd0);
`ifdef CALC_CHAIN_EN
    if (!last_err) begin
      check("chain_state", 32'(state_led), 32'd1);
      check("chain_alu_a", alu_a, last_disp);
      cur_a = last_disp;
      in_b = 1'b1;
    end else begin
      check("leave_state", 32'(state_led), 32'd0);
      in_b = 1'b0;
    end
`else
    check("leave_state", 32'(state_led), 32'd0);
    in_b = 1'b0;
`endif
    sw_data = $urandom;
    @(negedge clk);
    check("leave_disp_track", disp_value, sw_data);
  endtask

  task automatic pulse_clear(input string tag);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    check_cleared(tag);
    @(negedge clk);
    in_b = 1'b0;
  endtask

  task automatic fresh_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic [4:0] sh);
    if (in_b) pulse_clear("clr_to_a");
    enter_a(a);
    run_b(b, op, sh);
    leave_show();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pick_op();
    case ($urandom_range(0, 6))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_SRA;
      3: return OP_SRAV;
      4: return OP_SLT;
      5: return 5'($urandom_range(13, 31));
      default: return 5'($urandom_range(0, 12));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sw_data = 32'hA5A5_5A5A;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_track", disp_value, 32'hA5A5_5A5A);
    @(negedge clk);

    fresh_op(32'h7FFF_FFFF, 32'h0000_FFFF, OP_ADD, 5'd0);
    fresh_op(-32'sd10, 32'd100, OP_SLT, 5'd0);
    fresh_op(-32'sd10, 32'h0000_1234, OP_SRA, 5'd3);
    fresh_op(32'h0000_0005, 32'h0000_0006, 5'd20, 5'd9);

    // Clear while the operation is executing.
    if (in_b) pulse_clear("clr_to_a");
    enter_a(32'h1111_2222);
    sw_data = 32'h3333_4444;
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    check("abort_exec_state", 32'(state_led), 32'd2);
    pulse_clear("clear_in_exec");

    // Enter and clear together in GET_B: clear wins.
    enter_a(32'h5555_6666);
    sw_data = 32'h7777_8888;
    key_enter = 1'b1;
    key_clear = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    key_clear = 1'b0;
    check_cleared("enter_clear_same");
    @(negedge clk);
    in_b = 1'b0;

    // Enter key held through reset release must not register a press.
    reset = 1'b0;
    key_enter = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("held_key_state", 32'(state_led), 32'd0);
    check("held_key_alu_a", alu_a, 32'd0);
    key_enter = 1'b0;
    @(negedge clk);
    in_b = 1'b0;

`ifdef CALC_CHAIN_EN
    fresh_op(32'd5, 32'd3, OP_ADD, 5'd0);
    check("chain_in_b", 32'(in_b), 32'd1);
    run_b(32'd2, OP_ADD, 5'd0);
    check("chain_total", last_disp, 32'd10);
    leave_show();
`endif

    for (int i = 0; i < 40; i++) begin
      if (!in_b) enter_a(pick_val());
      run_b(pick_val(), pick_op(), 5'($urandom_range(0, 31)));
      leave_show();
    end

    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
